i2c_txn_sequencer: RTL and testbench
====================================

# i2c_txn_sequencer

Command-queue scheduler in front of the I2C master controller. Software or a DMA pushes transaction descriptors (target address, address mode, direction, byte count, chain flag) into a small FIFO. The sequencer presents one descriptor at a time to the master's buffer-load path and pulses the master's begin-transaction flag. It chains descriptors into repeated-START sequences, retries failed single transactions after a back-off, and reports per-descriptor completion or failure.

## Interface
- DEPTH, 4, descriptor FIFO entries (power of 2, ≥2)
- MAX_RETRY, 3, reissues allowed per unchained descriptor (only with retry compiled in)
- BACKOFF_CYCLES, 64, idle clk cycles between failure and reissue
- clk  in  1  clock
- n_rst  in  1  reset n_rst, asynchronous, active-low
- cmd_valid / cmd_ready  in/out  1/1  descriptor push handshake
- cmd_addr  in  10  target address (7-bit uses [6:0])
- cmd_addr_mode  in  1  0 = 7-bit, 1 = 10-bit
- cmd_dir  in  1  0 = RX, 1 = TX
- cmd_count  in  8  byte count (0 = address-only probe)
- cmd_chain  in  1  next descriptor follows via repeated START
- flush  in  1  drop all queued (not yet issued) descriptors
- ctrl_busy  in  1  master busy
- ctrl_complete  in  1  master set_transaction_complete pulse
- ctrl_ack_error  in  1  master set_ack_error pulse
- ctrl_arb_lost  in  1  master set_arbitration_lost pulse
- begin_set  out  1  one-cycle set pulse to master begin flag
- cur_addr, cur_addr_mode, cur_dir, cur_count  out  10/1/1/8  descriptor loaded by master
- seq_busy  out  1  descriptor active or pending
- done_pulse / fail_pulse  out  1/1  per-descriptor result, one cycle
- fail_code  out  2  0 none, 1 NACK, 2 arbitration lost, 3 retries exhausted; valid with fail_pulse
- queue_level  out  $clog2(DEPTH)+1  entries queued

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, ACTIVE, CHAIN_PEND, BACKOFF.
- IDLE: if queue non-empty, pop the head into the cur_* registers and go to ISSUE.
- ISSUE: assert begin_set for one cycle, clear the sticky error, then go to WAIT_BUSY.
- WAIT_BUSY: on ctrl_busy=1, go to ACTIVE if cur chain=0, else CHAIN_PEND.
- CHAIN_PEND: wait for the queue to be non-empty, then pulse begin_set once and go to ACTIVE with next_pending=1. If the queue is still empty at ctrl_complete, treat the descriptor as unchained.
- ACTIVE: ctrl_ack_error and ctrl_arb_lost set a sticky error (arb_lost has priority).
- On ctrl_complete with no error: done_pulse.
- On ctrl_complete with an error: fail_pulse with code 1 or 2.
- After ctrl_complete, if next_pending=1: pop the head into cur_* on the same edge. The next state is WAIT_BUSY when the new entry is unchained, otherwise CHAIN_PEND. A descriptor advanced to this way is never retried.
- After ctrl_complete, if next_pending=0: go to IDLE, or to BACKOFF when a retry applies.
- flush: queue emptied the same cycle; the active descriptor runs to completion. flush and push in the same cycle: flush wins, push dropped (cmd_ready=0 while flush=1).
- cmd_ready = !full && !flush. Push and pop in the same cycle are both honoured; level unchanged.

## Timing
- Reset: all outputs 0, queue empty, state IDLE. Reset mid-transaction abandons the descriptor with no result pulse.
- Push to begin_set with an empty idle sequencer: 2 cycles (pop edge, then ISSUE).
- cur_* stay stable from ISSUE until the edge after ctrl_complete. They update on that edge, so the master's LOAD_BUFFER (≥2 cycles after SR_SET_COMPLETE) sees the new values.
- done_pulse/fail_pulse coincide with the cycle after ctrl_complete.
- An error pulse and ctrl_complete in the same cycle count as error.

## Configuration
- I2C_SEQ_RETRY_EN defined:
  - A failed unchained descriptor enters BACKOFF for BACKOFF_CYCLES, then re-enters ISSUE with unchanged cur_*.
  - Intermediate failures produce no fail_pulse.
  - After MAX_RETRY reissues, it fails with code 3.
  - Retry counter is 2 bits minimum, sized $clog2(MAX_RETRY+1).
- Undefined: no BACKOFF state or counters; every failure reports immediately with code 1 or 2.

## Test plan
- Push {addr 0x50, 7-bit, TX, count 2, chain 0}; model master completes cleanly -> begin_set 2 cycles after push, cur_addr=0x50, one done_pulse, queue_level 1→0.
- Push chained TX 0x50 count 1 then RX 0x50 count 4 -> second begin_set while ctrl_busy=1; cur_* switch to RX/4 the edge after first ctrl_complete; two done_pulses, no idle gap.
- Unchained descriptor, master returns ctrl_ack_error each time, retry enabled, MAX_RETRY=3 -> 4 begin_sets spaced ≥64 idle cycles, single fail_pulse code 3; retry disabled -> one fail_pulse code 1.
- Fill DEPTH=4 entries -> cmd_ready=0; fifth push stalls; pop frees a slot same cycle; flush with a simultaneous push -> queue_level 0, push dropped, active descriptor still reports done.
- ctrl_arb_lost mid-TRANSMIT with chain pending -> fail_pulse code 2, next descriptor still issued, never retried.
- Assert n_rst during ACTIVE -> all outputs 0 immediately, queue_level 0, no pulses after release.

Source files
------------

// File: rtl/i2c_txn_sequencer.sv
// Descriptor FIFO and scheduler in front of the I2C master's buffer-load/begin path.
// Define I2C_SEQ_RETRY_EN to reissue failed unchained descriptors after a back-off.
module i2c_txn_sequencer #(
  parameter int DEPTH          = 4,
  parameter int MAX_RETRY      = 3,
  parameter int BACKOFF_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [9:0]             cmd_addr,
  input  logic                   cmd_addr_mode,
  input  logic                   cmd_dir,
  input  logic [7:0]             cmd_count,
  input  logic                   cmd_chain,
  input  logic                   flush,
  input  logic                   ctrl_busy,
  input  logic                   ctrl_complete,
  input  logic                   ctrl_ack_error,
  input  logic                   ctrl_arb_lost,
  output logic                   begin_set,
  output logic [9:0]             cur_addr,
  output logic                   cur_addr_mode,
  output logic                   cur_dir,
  output logic [7:0]             cur_count,
  output logic                   seq_busy,
  output logic                   done_pulse,
  output logic                   fail_pulse,
  output logic [1:0]             fail_code,
  output logic [$clog2(DEPTH):0] queue_level
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [9:0] addr;
    logic       mode;
    logic       dir;
    logic [7:0] count;
    logic       chain;
  } desc_t;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, ACTIVE, CHAIN_PEND
`ifdef I2C_SEQ_RETRY_EN
    , BACKOFF
`endif
  } state_t;

  desc_t         mem [DEPTH];
  desc_t         head, cur;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          empty, full, push, pop;
  state_t        state, state_n;
  logic          next_pending, no_retry, tracking, finish;
  logic          set_pend, clr_pend, clr_err, advanced, res_done, res_fail;
  logic [1:0]    err_code, err_now, res_code;

  assign empty       = (level == '0);
  assign full        = (level == (AW+1)'(DEPTH));
  assign cmd_ready   = !full && !flush;
  assign push        = cmd_valid && cmd_ready;
  assign head        = mem[rd_ptr];
  assign queue_level = level;
  assign seq_busy    = (state != IDLE) || !empty;
  assign tracking    = (state == WAIT_BUSY) || (state == ACTIVE) || (state == CHAIN_PEND);
  assign {cur_addr, cur_addr_mode, cur_dir, cur_count} = {cur.addr, cur.mode, cur.dir, cur.count};

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{cmd_addr, cmd_addr_mode, cmd_dir, cmd_count, cmd_chain};

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end

  // Arbitration loss outranks NACK, including an error arriving with ctrl_complete.
  always_comb begin
    if (ctrl_arb_lost || err_code == 2'd2)       err_now = 2'd2;
    else if (ctrl_ack_error || err_code == 2'd1) err_now = 2'd1;
    else                                         err_now = 2'd0;
  end

`ifdef I2C_SEQ_RETRY_EN
  localparam int RW = ($clog2(MAX_RETRY+1) < 2) ? 2 : $clog2(MAX_RETRY+1);
  localparam int BW = $clog2(BACKOFF_CYCLES+1);
  logic [RW-1:0] retry_cnt;
  logic [BW-1:0] bo_cnt;
  logic          retry_inc;

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      retry_cnt <= '0;
      bo_cnt    <= '0;
    end else begin
      if (pop)            retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
      bo_cnt <= (state == BACKOFF) ? bo_cnt + 1'b1 : '0;
    end
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_RETRY[0], BACKOFF_CYCLES[0]};
`endif

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    begin_set = 1'b0;
    set_pend  = 1'b0;
    clr_pend  = 1'b0;
    clr_err   = 1'b0;
    advanced  = 1'b0;
    finish    = 1'b0;
    res_done  = 1'b0;
    res_fail  = 1'b0;
    res_code  = 2'd0;
`ifdef I2C_SEQ_RETRY_EN
    retry_inc = 1'b0;
`endif
    case (state)
      IDLE: if (!empty && !flush) begin
        pop     = 1'b1;
        state_n = ISSUE;
      end
      ISSUE: begin
        begin_set = 1'b1;
        clr_err   = 1'b1;
        state_n   = WAIT_BUSY;
      end
      WAIT_BUSY: if (ctrl_busy) state_n = cur.chain ? CHAIN_PEND : ACTIVE;
      // Completion before a follower arrives ends the chain as if unchained.
      CHAIN_PEND:
        if (ctrl_complete) finish = 1'b1;
        else if (!empty && !flush) begin
          begin_set = 1'b1;
          set_pend  = 1'b1;
          state_n   = ACTIVE;
        end
      ACTIVE: if (ctrl_complete) finish = 1'b1;
`ifdef I2C_SEQ_RETRY_EN
      BACKOFF: if (bo_cnt == BW'(BACKOFF_CYCLES-1)) state_n = ISSUE;
`endif
      default: state_n = IDLE;
    endcase

    if (finish) begin
      state_n  = IDLE;
      res_done = (err_now == 2'd0);
      res_fail = (err_now != 2'd0);
      res_code = err_now;
      if (next_pending) begin
        clr_pend = 1'b1;
        // Master already began the follower; load it now for its LOAD_BUFFER.
        if (!empty && !flush) begin
          pop      = 1'b1;
          advanced = 1'b1;
          clr_err  = 1'b1;
          state_n  = head.chain ? CHAIN_PEND : WAIT_BUSY;
        end
      end
`ifdef I2C_SEQ_RETRY_EN
      else if (res_fail && !no_retry) begin
        if (retry_cnt < RW'(MAX_RETRY)) begin
          retry_inc = 1'b1;
          res_fail  = 1'b0;
          state_n   = BACKOFF;
        end else begin
          res_code = 2'd3;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state        <= IDLE;
      cur          <= '0;
      next_pending <= 1'b0;
      no_retry     <= 1'b0;
      err_code     <= 2'd0;
      done_pulse   <= 1'b0;
      fail_pulse   <= 1'b0;
      fail_code    <= 2'd0;
    end else begin
      state <= state_n;
      if (pop) begin
        cur      <= head;
        no_retry <= advanced;
      end
      if (set_pend)      next_pending <= 1'b1;
      else if (clr_pend) next_pending <= 1'b0;
      if (clr_err)       err_code <= 2'd0;
      else if (tracking) err_code <= err_now;
      done_pulse <= res_done;
      fail_pulse <= res_fail;
      fail_code  <= res_fail ? res_code : 2'd0;
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a hand-driven master model.
`timescale 1ns/1ps
module tb_i2c_txn_sequencer;
  logic       clk = 1'b0, n_rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [9:0] cmd_addr = '0;
  logic       cmd_addr_mode = 1'b0, cmd_dir = 1'b0, cmd_chain = 1'b0;
  logic [7:0] cmd_count = '0;
  logic       flush = 1'b0, ctrl_busy = 1'b0, ctrl_complete = 1'b0;
  logic       ctrl_ack_error = 1'b0, ctrl_arb_lost = 1'b0;
  logic       begin_set, cur_addr_mode, cur_dir, seq_busy, done_pulse, fail_pulse;
  logic [9:0] cur_addr;
  logic [7:0] cur_count;
  logic [1:0] fail_code;
  logic [2:0] queue_level;

`ifdef I2C_SEQ_RETRY_EN
  localparam int ATTEMPTS = 4, EXP_CODE = 3;
`else
  localparam int ATTEMPTS = 1, EXP_CODE = 1;
`endif

  always #5 clk = ~clk;

  i2c_txn_sequencer dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_addr_mode(cmd_addr_mode), .cmd_dir(cmd_dir),
    .cmd_count(cmd_count), .cmd_chain(cmd_chain), .flush(flush),
    .ctrl_busy(ctrl_busy), .ctrl_complete(ctrl_complete),
    .ctrl_ack_error(ctrl_ack_error), .ctrl_arb_lost(ctrl_arb_lost),
    .begin_set(begin_set), .cur_addr(cur_addr), .cur_addr_mode(cur_addr_mode),
    .cur_dir(cur_dir), .cur_count(cur_count), .seq_busy(seq_busy),
    .done_pulse(done_pulse), .fail_pulse(fail_pulse), .fail_code(fail_code),
    .queue_level(queue_level)
  );

  int n_chk = 0, n_pass = 0;
  int n_begin = 0, n_done = 0, n_fail = 0;
  int b0, d0, f0, waited;
  bit ok;

  always @(negedge clk) begin
    if (begin_set)  n_begin++;
    if (done_pulse) n_done++;
    if (fail_pulse) n_fail++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cmd(input logic [9:0] a, input logic m, input logic d,
                         input logic [7:0] c, input logic ch);
    cmd_addr = a; cmd_addr_mode = m; cmd_dir = d; cmd_count = c; cmd_chain = ch;
    cmd_valid = 1'b1;
  endtask

  task automatic complete(input logic ack, input logic arb, input logic keep_busy);
    ctrl_complete = 1'b1; ctrl_ack_error = ack; ctrl_arb_lost = arb;
    if (!keep_busy) ctrl_busy = 1'b0;
    tick();
    ctrl_complete = 1'b0; ctrl_ack_error = 1'b0; ctrl_arb_lost = 1'b0;
  endtask

  task automatic wait_begin(input int max, output int w, output bit found);
    w = 0; found = 1'b0;
    while (w < max && !found) begin
      tick(); w++;
      if (begin_set) found = 1'b1;
    end
  endtask

  task automatic snap();
    b0 = n_begin; d0 = n_done; f0 = n_fail;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    tick(); tick();
    check("rst_begin", begin_set, 0);
    check("rst_busy", seq_busy, 0);
    check("rst_level", queue_level, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_pulses", {done_pulse, fail_pulse, fail_code}, 0);
    n_rst = 1'b1;
    tick();

    // single clean TX descriptor
    snap();
    set_cmd(10'h050, 1'b0, 1'b1, 8'd2, 1'b0);
    tick(); cmd_valid = 1'b0;
    check("t1_level1", queue_level, 1);
    check("t1_nobegin", begin_set, 0);
    tick();
    check("t1_begin", begin_set, 1);
    check("t1_addr", cur_addr, 10'h050);
    check("t1_level0", queue_level, 0);
    ctrl_busy = 1'b1;
    tick(); tick(); tick();
    complete(1'b0, 1'b0, 1'b0);
    check("t1_done", done_pulse, 1);
    tick();
    check("t1_done_cnt", n_done - d0, 1);
    check("t1_begin_cnt", n_begin - b0, 1);
    check("t1_idle", seq_busy, 0);

    // chained TX 1 -> RX 4 via repeated START
    snap();
    set_cmd(10'h050, 1'b0, 1'b1, 8'd1, 1'b1);
    tick();
    set_cmd(10'h050, 1'b0, 1'b0, 8'd4, 1'b0);
    tick(); cmd_valid = 1'b0;
    check("t2_issue", begin_set, 1);
    check("t2_cnt_a", cur_count, 1);
    check("t2_level", queue_level, 1);
    ctrl_busy = 1'b1;
    tick(); tick();
    check("t2_chain_begin", begin_set, 1);
    tick();
    check("t2_single", begin_set, 0);
    tick();
    check("t2_stable", cur_count, 1);
    complete(1'b0, 1'b0, 1'b1);
    check("t2_done1", done_pulse, 1);
    check("t2_dir", cur_dir, 0);
    check("t2_cnt_b", cur_count, 4);
    check("t2_level0", queue_level, 0);
    check("t2_busy", seq_busy, 1);
    tick();
    complete(1'b0, 1'b0, 1'b0);
    check("t2_done2", done_pulse, 1);
    tick();
    check("t2_begin_cnt", n_begin - b0, 2);
    check("t2_done_cnt", n_done - d0, 2);

    // NACK on every attempt
    snap();
    set_cmd(10'h03C, 1'b0, 1'b1, 8'd1, 1'b0);
    tick(); cmd_valid = 1'b0;
    for (int a = 0; a < ATTEMPTS; a++) begin
      wait_begin(200, waited, ok);
      check("t3_begin", ok, 1);
      if (a > 0) check("t3_gap", 32'(waited >= 64), 1);
      ctrl_busy = 1'b1;
      tick(); tick();
      complete(1'b1, 1'b0, 1'b0);
      if (a < ATTEMPTS - 1) check("t3_quiet", fail_pulse, 0);
      else begin
        check("t3_fail", fail_pulse, 1);
        check("t3_code", fail_code, EXP_CODE);
      end
    end
    repeat (3) tick();
    check("t3_fail_cnt", n_fail - f0, 1);
    check("t3_begin_cnt", n_begin - b0, ATTEMPTS);

    // full queue, stall, pop frees slot, flush drops a simultaneous push
    snap();
    set_cmd(10'h010, 1'b0, 1'b1, 8'd1, 1'b0);
    tick(); cmd_valid = 1'b0;
    tick();
    ctrl_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_cmd(10'(16 + i), 1'b0, 1'b1, 8'd1, 1'b0);
      tick();
    end
    set_cmd(10'h015, 1'b0, 1'b1, 8'd1, 1'b0);
    check("t4_full", queue_level, 4);
    check("t4_ready", cmd_ready, 0);
    tick();
    check("t4_stall", queue_level, 4);
    complete(1'b0, 1'b0, 1'b0);
    check("t4_done0", done_pulse, 1);
    tick();
    check("t4_pop_ready", cmd_ready, 1);
    check("t4_pop_level", queue_level, 3);
    check("t4_addr", cur_addr, 10'h011);
    tick(); cmd_valid = 1'b0;
    check("t4_refill", queue_level, 4);
    ctrl_busy = 1'b1;
    tick();
    flush = 1'b1;
    set_cmd(10'h016, 1'b0, 1'b1, 8'd1, 1'b0);
    #1 check("t4_flush_ready", cmd_ready, 0);
    tick(); flush = 1'b0; cmd_valid = 1'b0;
    check("t4_flushed", queue_level, 0);
    complete(1'b0, 1'b0, 1'b0);
    check("t4_done1", done_pulse, 1);
    repeat (4) tick();
    check("t4_begin_cnt", n_begin - b0, 2);
    check("t4_idle", seq_busy, 0);

    // arbitration lost with a chained follower pending
    snap();
    set_cmd(10'h020, 1'b0, 1'b1, 8'd2, 1'b1);
    tick();
    set_cmd(10'h021, 1'b0, 1'b0, 8'd3, 1'b0);
    tick(); cmd_valid = 1'b0;
    check("t5_issue", begin_set, 1);
    ctrl_busy = 1'b1;
    tick(); tick();
    check("t5_chain", begin_set, 1);
    tick();
    ctrl_arb_lost = 1'b1;
    tick(); ctrl_arb_lost = 1'b0;
    tick();
    complete(1'b0, 1'b0, 1'b1);
    check("t5_fail", fail_pulse, 1);
    check("t5_code", fail_code, 2);
    check("t5_addr", cur_addr, 10'h021);
    check("t5_dir", cur_dir, 0);
    tick();
    complete(1'b1, 1'b0, 1'b0);
    check("t5_fail_b", fail_pulse, 1);
    check("t5_code_b", fail_code, 1);
    repeat (80) tick();
    check("t5_noretry", n_begin - b0, 2);
    check("t5_fail_cnt", n_fail - f0, 2);
    check("t5_done_cnt", n_done - d0, 0);

    // reset while ACTIVE
    set_cmd(10'h033, 1'b0, 1'b1, 8'd5, 1'b0);
    tick(); cmd_valid = 1'b0;
    tick();
    ctrl_busy = 1'b1;
    tick(); tick();
    set_cmd(10'h034, 1'b0, 1'b1, 8'd1, 1'b0);
    tick(); cmd_valid = 1'b0;
    check("t6_queued", queue_level, 1);
    n_rst = 1'b0;
    #1;
    check("t6_begin", begin_set, 0);
    check("t6_busy", seq_busy, 0);
    check("t6_level", queue_level, 0);
    check("t6_cur", {cur_addr, cur_count}, 0);
    snap();
    tick();
    n_rst = 1'b1;
    complete(1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    check("t6_quiet", (n_begin - b0) + (n_done - d0) + (n_fail - f0), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
